// File: rtl/hv_abist_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hv_abist_seq : steps the six HV analog BIST enables one window at a time    |
// |                and collects the checker's per-item pass status.            |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module hv_abist_seq #(
  parameter int CLK_M         = 48,
  parameter int OV_WIN_US     = 72,
  parameter int SHORT_WIN_US  = 2,
  parameter int ADC_WIN_US    = 5,
  parameter int GAP_CYC       = 4,
  parameter int BIST_ITEM_NUM = 6
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_bist_start,
  input  logic                     i_bist_abort,
  input  logic [BIST_ITEM_NUM-1:0] i_bist_item_mask,
  input  logic [BIST_ITEM_NUM-1:0] i_bist_status,
  output logic                     o_bist_hv_ov,
  output logic                     o_bist_hv_ot,
  output logic                     o_bist_hv_opscod,
  output logic                     o_bist_hv_oc,
  output logic                     o_bist_hv_sc,
  output logic                     o_bist_hv_adc,
  output logic                     o_bist_busy,
  output logic                     o_bist_done,
  output logic [BIST_ITEM_NUM-1:0] o_bist_result,
  output logic                     o_bist_fail,
  output logic                     o_bist_aborted
);

  localparam int OV_WIN    = OV_WIN_US * CLK_M;
  localparam int SHORT_WIN = SHORT_WIN_US * CLK_M;
  localparam int ADC_WIN   = ADC_WIN_US * CLK_M;
  localparam int MAX_WIN0  = (OV_WIN > ADC_WIN) ? OV_WIN : ADC_WIN;
  localparam int MAX_WIN1  = (MAX_WIN0 > SHORT_WIN) ? MAX_WIN0 : SHORT_WIN;
  // The gap shares the window counter, so it must fit as well.
  localparam int MAX_CNT   = (MAX_WIN1 > GAP_CYC) ? MAX_WIN1 : GAP_CYC;
  localparam int CNT_W     = $clog2(MAX_CNT);
  localparam int IDX_W     = $clog2(BIST_ITEM_NUM + 1);

  localparam logic [CNT_W-1:0] OV_LAST    = CNT_W'(OV_WIN - 1);
  localparam logic [CNT_W-1:0] SHORT_LAST = CNT_W'(SHORT_WIN - 1);
  localparam logic [CNT_W-1:0] ADC_LAST   = CNT_W'(ADC_WIN - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_END    = IDX_W'(BIST_ITEM_NUM);
  localparam logic [IDX_W-1:0] IDX_ADC    = IDX_W'(BIST_ITEM_NUM - 1);
  localparam logic [BIST_ITEM_NUM-1:0] ONE_HOT0 = {{(BIST_ITEM_NUM-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEL    = 3'd1,
    RUN    = 3'd2,
    SAMPLE = 3'd3,
    GAP    = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t                   state_q,   state_d;
  logic [IDX_W-1:0]         idx_q,     idx_d;
  logic [CNT_W-1:0]         cnt_q,     cnt_d;
  logic [BIST_ITEM_NUM-1:0] mask_q,    mask_d;
  logic [BIST_ITEM_NUM-1:0] result_q,  result_d;
  logic [BIST_ITEM_NUM-1:0] en_q,      en_d;
  logic                     fail_q,    fail_d;
  logic                     aborted_q, aborted_d;
  logic [CNT_W-1:0]         win_last;

  always_comb begin
    win_last = SHORT_LAST;
    if (idx_q == '0)
      win_last = OV_LAST;
    else if (idx_q == IDX_ADC)
      win_last = ADC_LAST;
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    mask_d    = mask_q;
    result_d  = result_q;
    fail_d    = fail_q;
    aborted_d = aborted_q;

    case (state_q)
      IDLE: begin
        if (i_bist_start) begin
          mask_d    = i_bist_item_mask;
          result_d  = '0;
          fail_d    = 1'b0;
          aborted_d = 1'b0;
          idx_d     = '0;
          cnt_d     = '0;
          state_d   = SEL;
        end
      end
      SEL: begin
        if (idx_q == IDX_END) begin
          state_d = DONE;
        end else if (mask_q[idx_q]) begin
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      RUN: begin
        if (cnt_q == win_last) begin
          cnt_d   = '0;
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SAMPLE: begin
        // Enable dropped last edge; the checker's status register has now settled.
        result_d[idx_q] = i_bist_status[idx_q];
        cnt_d           = '0;
        state_d         = GAP;
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          idx_d   = idx_q + 1'b1;
          state_d = SEL;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        fail_d  = fail_q | (|(mask_q & ~result_q));
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (i_bist_abort && (state_q == SEL || state_q == RUN ||
                         state_q == SAMPLE || state_q == GAP)) begin
      result_d  = result_q;
      idx_d     = idx_q;
      cnt_d     = '0;
      fail_d    = 1'b1;
      aborted_d = 1'b1;
      state_d   = DONE;
    end

    en_d = (state_d == RUN) ? (ONE_HOT0 << idx_d) : '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      mask_q    <= '0;
      result_q  <= '0;
      en_q      <= '0;
      fail_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      mask_q    <= mask_d;
      result_q  <= result_d;
      en_q      <= en_d;
      fail_q    <= fail_d;
      aborted_q <= aborted_d;
    end
  end

  assign o_bist_hv_ov     = en_q[0];
  assign o_bist_hv_ot     = en_q[1];
  assign o_bist_hv_opscod = en_q[2];
  assign o_bist_hv_oc     = en_q[3];
  assign o_bist_hv_sc     = en_q[4];
  assign o_bist_hv_adc    = en_q[5];
  assign o_bist_busy      = (state_q != IDLE);
  assign o_bist_done      = (state_q == DONE);
  assign o_bist_result    = result_q;
  assign o_bist_fail      = fail_q;
  assign o_bist_aborted   = aborted_q;

endmodule
`default_nettype wire

// File: tb/tb_hv_abist_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_hv_abist_seq : directed self-checking bench for hv_abist_seq             |
// | Revision        : 1.0                                                      |
// +----------------------------------------------------------------------------+
module tb_hv_abist_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [5:0] mask = '0;
  logic [5:0] status = '0;
  logic       ov, ot, opscod, oc, sc, adc;
  logic       busy, done, fail, aborted;
  logic [5:0] result;
  logic [5:0] en;

  int cmp_cnt = 0;
  int err_cnt = 0;

  int rises [6];
  int width [6];
  int len   [6];
  int order [$];
  int ovl, done_cnt, low_run, min_gap, seen_fall;
  logic [5:0] en_prev;

  always #5 clk = ~clk;

  hv_abist_seq dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_bist_start     (start),
    .i_bist_abort     (abort),
    .i_bist_item_mask (mask),
    .i_bist_status    (status),
    .o_bist_hv_ov     (ov),
    .o_bist_hv_ot     (ot),
    .o_bist_hv_opscod (opscod),
    .o_bist_hv_oc     (oc),
    .o_bist_hv_sc     (sc),
    .o_bist_hv_adc    (adc),
    .o_bist_busy      (busy),
    .o_bist_done      (done),
    .o_bist_result    (result),
    .o_bist_fail      (fail),
    .o_bist_aborted   (aborted)
  );

  assign en = {adc, sc, oc, opscod, ot, ov};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic mon_clr();
    for (int i = 0; i < 6; i++) begin
      rises[i] = 0; width[i] = 0; len[i] = 0;
    end
    order.delete();
    ovl = 0; done_cnt = 0; low_run = 0; min_gap = 1000000; seen_fall = 0;
    en_prev = en;
  endtask

  // One clock advance; enables are observed at every falling edge.
  task automatic tick();
    @(negedge clk);
    if ($countones(en) > 1) ovl++;
    if (done) done_cnt++;
    for (int i = 0; i < 6; i++) begin
      if (en[i] && !en_prev[i]) begin
        rises[i]++;
        order.push_back(i);
        len[i] = 1;
        if (seen_fall != 0 && low_run < min_gap) min_gap = low_run;
      end else if (en[i]) begin
        len[i]++;
      end else if (en_prev[i]) begin
        width[i] = len[i];
        seen_fall = 1;
      end
    end
    if (en == 6'h00) low_run++;
    else low_run = 0;
    en_prev = en;
  endtask

  task automatic start_pulse(input logic [5:0] m, output int n);
    mask  = m;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
  endtask

  task automatic wait_done(input string tag, input int n_in, output int n_out);
    int n;
    n = n_in;
    while (!done && n < 20000) begin
      tick();
      n++;
    end
    if (!done) chk({tag, "_timeout"}, 32'(n), 32'd0);
    n_out = n;
    tick();
  endtask

  initial begin
    int n;
    int exp_w [6];
    exp_w = '{3456, 96, 96, 96, 96, 240};

    mon_clr();
    repeat (3) @(negedge clk);
    chk("rst_en",      32'(en), 32'h0);
    chk("rst_busy",    32'(busy), 32'd0);
    chk("rst_done",    32'(done), 32'd0);
    chk("rst_result",  32'(result), 32'h0);
    chk("rst_fail",    32'(fail), 32'd0);
    chk("rst_aborted", 32'(aborted), 32'd0);
    rst_n = 1'b1;
    tick();

    // All items masked: only the six SEL skips plus the terminating SEL.
    mon_clr();
    start_pulse(6'h00, n);
    chk("m00_busy", 32'(busy), 32'd1);
    wait_done("m00", n, n);
    chk("m00_done_cycle", 32'(n), 32'd8);
    chk("m00_rises", 32'(order.size()), 32'd0);
    chk("m00_result", 32'(result), 32'h00);
    chk("m00_fail", 32'(fail), 32'd0);
    chk("m00_idle", 32'(busy), 32'd0);

    // Single ot item passing.
    mon_clr();
    status = 6'h02;
    start_pulse(6'h02, n);
    wait_done("m02", n, n);
    repeat (3) tick();
    chk("m02_ot_width", 32'(width[1]), 32'd96);
    chk("m02_rises", 32'(order.size()), 32'd1);
    chk("m02_result", 32'(result), 32'h02);
    chk("m02_fail", 32'(fail), 32'd0);
    chk("m02_done_cnt", 32'(done_cnt), 32'd1);

    // Full sequence, everything passing.
    mon_clr();
    status = 6'h3F;
    start_pulse(6'h3F, n);
    wait_done("m3f", n, n);
    chk("m3f_rises", 32'(order.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < order.size()) chk($sformatf("m3f_order%0d", i), 32'(order[i]), 32'(i));
      chk($sformatf("m3f_width%0d", i), 32'(width[i]), 32'(exp_w[i]));
    end
    chk("m3f_overlap", 32'(ovl), 32'd0);
    chk("m3f_gap_ge5", 32'(min_gap >= 5), 32'd1);
    chk("m3f_result", 32'(result), 32'h3F);
    chk("m3f_fail", 32'(fail), 32'd0);

    // ov passes, adc fails.
    mon_clr();
    status = 6'h01;
    start_pulse(6'h21, n);
    wait_done("m21", n, n);
    chk("m21_result", 32'(result), 32'h01);
    chk("m21_fail", 32'(fail), 32'd1);
    chk("m21_aborted", 32'(aborted), 32'd0);
    chk("m21_rises", 32'(rises[0] + rises[5]), 32'd2);

    // Abort 50 cycles into the ot window.
    mon_clr();
    status = 6'h3F;
    start_pulse(6'h3F, n);
    n = 0;
    while (!ot && n < 5000) begin tick(); n++; end
    chk("abt_ot_seen", 32'(ot), 32'd1);
    repeat (49) tick();
    chk("abt_ot_before", 32'(ot), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abt_ot_drop", 32'(ot), 32'd0);
    chk("abt_done", 32'(done), 32'd1);
    chk("abt_aborted", 32'(aborted), 32'd1);
    chk("abt_fail", 32'(fail), 32'd1);
    tick();
    chk("abt_idle", 32'(busy), 32'd0);
    chk("abt_result", 32'(result), 32'h01);
    repeat (400) tick();
    chk("abt_later_rises", 32'(rises[2] + rises[3] + rises[4] + rises[5]), 32'd0);
    chk("abt_done_cnt", 32'(done_cnt), 32'd1);

    // Restart while busy must be ignored.
    mon_clr();
    status = 6'h02;
    start_pulse(6'h02, n);
    repeat (10) tick();
    start_pulse(6'h3F, n);
    wait_done("restart", n, n);
    chk("restart_ov", 32'(rises[0]), 32'd0);
    chk("restart_result", 32'(result), 32'h02);

    // Asynchronous reset in the middle of the ov window.
    mon_clr();
    status = 6'h3F;
    start_pulse(6'h01, n);
    repeat (100) tick();
    chk("rst_mid_ov_on", 32'(ov), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_en", 32'(en), 32'h0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_outs", 32'({done, fail, aborted, result}), 32'h0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("rst_mid_stay", 32'({busy, en}), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hv_abist_seq.md
Name: hv_abist_seq

Overview:
- Sequencer (initiator) for the HV analog BIST checker.
- On a start request it drives the six per-item BIST enables (ov, ot, opscod, oc, sc, adc) one at a time, each for a fixed window.
- Between windows it drops all enables so the checker's window counter returns to zero, then samples the checker's per-item pass status.
- It reports a per-item result vector, an aggregate fail flag and a done pulse to the LV-side control/register logic.

Parameters:
- CLK_M, 48, clock cycles per microsecond.
- OV_WIN_US, 72, enable window for the ov item, in us.
- SHORT_WIN_US, 2, enable window for the ot, opscod, oc and sc items, in us.
- ADC_WIN_US, 5, enable window for the adc item, in us.
- GAP_CYC, 4, cycles with all enables low after each item's sample cycle; minimum 1.
- BIST_ITEM_NUM, 6, number of items; fixed at 6.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_bist_start  in  1  single-cycle start request; honoured only in IDLE.
- i_bist_abort  in  1  level; abort the running sequence.
- i_bist_item_mask  in  6  per-item run enable; bit0 ov, 1 ot, 2 opscod, 3 oc, 4 sc, 5 adc.
- i_bist_status  in  6  checker pass status, same bit order; sticky in the checker.
- o_bist_hv_ov  out  1  enable for the ov item.
- o_bist_hv_ot  out  1  enable for the ot item.
- o_bist_hv_opscod  out  1  enable for the opscod item.
- o_bist_hv_oc  out  1  enable for the oc item.
- o_bist_hv_sc  out  1  enable for the sc item.
- o_bist_hv_adc  out  1  enable for the adc item.
- o_bist_busy  out  1  high in every state except IDLE.
- o_bist_done  out  1  one-cycle pulse at sequence end or abort.
- o_bist_result  out  6  per-item result; 1 = pass.
- o_bist_fail  out  1  set when any enabled item failed, or on abort.
- o_bist_aborted  out  1  set when the last sequence was aborted.

Behaviour:
- Reset: all outputs 0; state IDLE; item index 0; counter 0.
- Enables are registered outputs and are never glitchy.
- At most one enable is high in any cycle, in every state.

- Window lengths in cycles:
  - ov: OV_WIN_US*CLK_M (default 3456).
  - ot, opscod, oc, sc: SHORT_WIN_US*CLK_M (default 96).
  - adc: ADC_WIN_US*CLK_M (default 240).
  - Counter width is $clog2 of the largest window.

- FSM states: IDLE, SEL, RUN, SAMPLE, GAP, DONE.
- IDLE:
  - On i_bist_start: capture the mask, clear result/fail/aborted, set index to 0, go to SEL.
  - i_bist_start in any other state is ignored.
- SEL:
  - index==6: go to DONE.
  - Else, captured mask bit set: go to RUN with counter=0.
  - Else: index+1, stay in SEL. Each skipped item costs exactly one cycle.
- RUN:
  - Enable[index] is high and the counter increments.
  - When counter==WIN-1, go to SAMPLE. The enable is therefore high for exactly WIN cycles.
- SAMPLE (1 cycle):
  - All enables low.
  - result[index] <= i_bist_status[index], covering the checker's one-cycle register latency.
  - Go to GAP with counter=0.
- GAP:
  - All enables low for GAP_CYC cycles.
  - Then index+1 and go to SEL.
- DONE (1 cycle):
  - o_bist_done=1.
  - o_bist_fail <= |(mask & ~result).
  - Go to IDLE.
- Result bits of masked items stay 0 and do not contribute to fail.
- result, fail and aborted hold until the next accepted start.

- Abort:
  - i_bist_abort in SEL, RUN, SAMPLE or GAP causes all enables to go low the next cycle and the FSM to go to DONE.
  - In DONE after abort: o_bist_done=1, o_bist_fail=1, o_bist_aborted=1.
  - Partially collected results are retained.
  - Abort in IDLE or DONE has no effect.
  - Abort has priority over every other transition in the same cycle.
- Asynchronous reset mid-sequence drops all enables immediately and returns to IDLE with outputs cleared.
- The checker status is sticky, so a pass from an earlier sequence persists until the checker is reset. System integration resets the checker between sequences; this block does not clear it.

Test Plan:
- Mask=6'h00, start pulse: no enable ever rises; o_bist_done high in the 8th cycle after the start; result=0, fail=0.
- Mask=6'h02, status[1] tied 1: o_bist_hv_ot high exactly 96 cycles; result=6'h02, fail=0, done once.
- Mask=6'h3F, all status 1:
  - Enables rise in order ov, ot, opscod, oc, sc, adc, with widths 3456, 96, 96, 96, 96, 240.
  - Each enable is separated from the next by ≥5 low cycles.
  - Never two enables high at once; result=6'h3F, fail=0.
- Mask=6'h21, status[0]=1, status[5]=0: result=6'h01, fail=1.
- Mask=6'h3F, abort 50 cycles into ot:
  - ot drops the next cycle; done pulses; aborted=1, fail=1.
  - result bit0 reflects the ov sample; no later enable rises.
- Second start while busy is ignored; a reset pulse during the ov window drops the enable asynchronously, and all outputs read 0.
